// File: rtl/fetch_decode.sv
// Instruction register plus combinational decoder with branch/HALT handling; FETCH_DECODE_PERF_CNT_EN adds a saturating taken-branch counter.
// Latency: fetch-to-decode 1 cycle; decode outputs are combinational from ir.
// Backpressure: none; a taken branch inserts a one-cycle bubble, and HALT freezes fetch until reset.
module fetch_decode #(
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         PC,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               zero,
  output logic               branch,
  output logic               branch_conditional,
  output logic [6:0]         target,
  output logic [2:0]         alu_op,
  output logic [5:0]         operand,
  output logic               ir_valid,
  output logic               done,
  output logic [CNT_W-1:0]   br_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               ir_vld_q;
  logic [2:0]         opcode;
  logic [2:0]         lut_idx;
  logic               is_halt;
  logic               taken;

  assign opcode   = ir[INSTR_W-1 -: 3];
  assign lut_idx  = ir[5:3];
  assign is_halt  = (opcode == 3'b111) && (lut_idx == 3'b111);
  assign operand  = ir[5:0];
  assign ir_valid = ir_vld_q;
  assign taken    = branch & ir_vld_q & (~branch_conditional | zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      ir       <= '0;
      ir_vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // ir stays frozen on the edge that enters HALT and while halted
      if (state == S_RUN && state_nxt == S_RUN) begin
        ir       <= instr_data;
        ir_vld_q <= ~taken;
      end else begin
        ir_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    branch             = 1'b0;
    branch_conditional = 1'b0;
    target             = {lut_idx, 4'b0000};
    alu_op             = 3'b000;
    done               = 1'b0;
    case (state)
      S_RUN: begin
        if (ir_vld_q) begin
          alu_op = opcode;
          if (opcode == 3'b110) begin
            branch = 1'b1;
          end else if (opcode == 3'b111) begin
            branch = 1'b1;
            if (is_halt) begin
              target    = PC;
              state_nxt = S_HALT;
            end else begin
              branch_conditional = 1'b1;
            end
          end
        end
      end
      S_HALT: begin
        // Branch-to-self keeps the program counter pinned
        branch = 1'b1;
        target = PC;
        done   = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

`ifdef FETCH_DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (taken && !is_halt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign br_count = cnt_q;
`else
  assign br_count = '0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: directed program with an external PC model, per-cycle expectations queued and checked at negedge.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero;
  logic [6:0]  pc;
  logic [6:0]  nxt;
  logic [8:0]  instr_data;
  logic        branch;
  logic        branch_conditional;
  logic [6:0]  target;
  logic [2:0]  alu_op;
  logic [5:0]  operand;
  logic        ir_valid;
  logic        done;
  logic [15:0] br_count;

  logic [8:0] rom [0:127];

  always #5 clk = ~clk;

  assign instr_data = rom[pc];

  fetch_decode #(.INSTR_W(9), .CNT_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .PC                 (pc),
    .instr_data         (instr_data),
    .zero               (zero),
    .branch             (branch),
    .branch_conditional (branch_conditional),
    .target             (target),
    .alu_op             (alu_op),
    .operand            (operand),
    .ir_valid           (ir_valid),
    .done               (done),
    .br_count           (br_count)
  );

  typedef struct {
    bit       rst;
    bit       z;
    bit [6:0] pc;
    bit       v;
    bit [2:0] op;
    bit [5:0] opd;
    bit       br;
    bit       cnd;
    bit [6:0] tgt;
    bit       dn;
    int       cnt;
  } row_t;

  row_t exp_q[$];
  row_t rows[$];
  row_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic row_t r(bit rst, bit z, bit [6:0] p, bit v, bit [2:0] op, bit [5:0] opd,
                             bit br, bit cnd, bit [6:0] tgt, bit dn, int cnt);
    row_t t;
    t.rst = rst; t.z = z; t.pc = p; t.v = v; t.op = op; t.opd = opd;
    t.br = br; t.cnd = cnd; t.tgt = tgt; t.dn = dn; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Program counter environment: follows branch requests, resets to 0
  initial begin
    pc = 7'd0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1)
        nxt = 7'd0;
      else if (branch === 1'b1 && (branch_conditional === 1'b0 || zero === 1'b1))
        nxt = target;
      else
        nxt = pc + 7'd1;
      @(posedge clk);
      #1 pc = nxt;
    end
  end

  // Monitor: pops the expectation for the current cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pc", {25'd0, pc}, {25'd0, mon_e.pc});
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, mon_e.v});
        chk("alu_op", {29'd0, alu_op}, {29'd0, mon_e.op});
        chk("branch", {31'd0, branch}, {31'd0, mon_e.br});
        chk("branch_conditional", {31'd0, branch_conditional}, {31'd0, mon_e.cnd});
        chk("done", {31'd0, done}, {31'd0, mon_e.dn});
        if (mon_e.br)
          chk("target", {25'd0, target}, {25'd0, mon_e.tgt});
        if (mon_e.v)
          chk("operand", {26'd0, operand}, {26'd0, mon_e.opd});
`ifdef FETCH_DECODE_PERF_CNT_EN
        chk("br_count", {16'd0, br_count}, mon_e.cnt);
`else
        chk("br_count", {16'd0, br_count}, 32'd0);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 9'd0;
    rom[0]  = 9'b000_000001;
    rom[1]  = 9'b001_000010;
    rom[2]  = 9'b010_000011;
    rom[3]  = 9'b011_000100;
    rom[4]  = 9'b100_000101;
    rom[5]  = 9'b110_010_000;  // BR -> 32
    rom[6]  = 9'b101_000000;   // delay slot, flushed
    rom[16] = 9'b110_011_000;  // BR -> 48
    rom[17] = 9'b110_000_000;  // second BR, flushed
    rom[32] = 9'b001_101010;
    rom[33] = 9'b111_001_000;  // BZ -> 16, zero=0
    rom[34] = 9'b010_010101;
    rom[35] = 9'b111_001_000;  // BZ -> 16, zero=1
    rom[36] = 9'b011_000000;   // flushed
    rom[48] = 9'b111_111_000;  // HALT
    rom[49] = 9'b100_000000;

    //            rst z  pc  v op opd br c tgt dn cnt
    rows.push_back(r(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 1,  1, 0, 1,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 2,  1, 1, 2,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 3,  1, 2, 3,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 4,  1, 3, 4,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 5,  1, 4, 5,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 6,  1, 6, 16, 1, 0, 32, 0, 0));
    rows.push_back(r(0, 0, 32, 0, 0, 0,  0, 0, 0,  0, 1));
    rows.push_back(r(0, 0, 33, 1, 1, 42, 0, 0, 0,  0, 1));
    rows.push_back(r(0, 0, 34, 1, 7, 8,  1, 1, 16, 0, 1));
    rows.push_back(r(0, 0, 35, 1, 2, 21, 0, 0, 0,  0, 1));
    rows.push_back(r(0, 1, 36, 1, 7, 8,  1, 1, 16, 0, 1));
    rows.push_back(r(0, 0, 16, 0, 0, 0,  0, 0, 0,  0, 2));
    rows.push_back(r(0, 0, 17, 1, 6, 24, 1, 0, 48, 0, 2));
    rows.push_back(r(0, 0, 48, 0, 0, 0,  0, 0, 0,  0, 3));
    rows.push_back(r(0, 0, 49, 1, 7, 56, 1, 0, 49, 0, 3));
    for (int k = 16; k <= 26; k++)
      rows.push_back(r(k == 26, 0, 49, 0, 0, 0, 1, 0, 49, 1, 3));
    rows.push_back(r(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 1,  1, 0, 1,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 2,  1, 1, 2,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 3,  1, 2, 3,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 4,  1, 3, 4,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 5,  1, 4, 5,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 6,  1, 6, 16, 1, 0, 32, 0, 0));
    rows.push_back(r(1, 0, 32, 0, 0, 0,  0, 0, 0,  0, 1));  // reset mid-flush
    rows.push_back(r(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0));
    rows.push_back(r(0, 0, 1,  1, 0, 1,  0, 0, 0,  0, 0));

    reset = 1'b1;
    zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < rows.size(); i++) begin
      reset = rows[i].rst;
      zero  = rows[i].z;
      exp_q.push_back(rows[i]);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter INSTR_W, default 9: instruction word width; the opcode is bits [8:6] and the operand field is bits [5:0].
REQ-002 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-003 clk  in  1: the single clock; every register updates on posedge clk.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 PC  in  7: current program counter, the same value that addresses the instruction ROM.
REQ-006 instr_data  in  9: ROM read data for address PC; combinational and valid in the same cycle.
REQ-007 zero  in  1: ALU zero flag for the instruction currently held in the instruction register.
REQ-008 branch  out  1: branch request to the program counter.
REQ-009 branch_conditional  out  1: when 1, the branch is taken only if zero is 1.
REQ-010 target  out  7: branch destination.
REQ-011 alu_op  out  3: opcode of the held instruction; 0 when the held instruction is not valid.
REQ-012 operand  out  6: bits [5:0] of the held instruction.
REQ-013 ir_valid  out  1: the instruction register holds a live, non-flushed instruction.
REQ-014 done  out  1: the program has halted.
REQ-015 br_count  out  CNT_W: count of taken branches (see Configuration).

Function
REQ-016 Instruction register ir SHALL capture instr_data on every clock edge while state is RUN; ir_valid SHALL become 1 on that edge unless a flush applies.
REQ-017 Decode of ir SHALL be combinational, so outputs reflect ir within the same cycle (fetch-to-decode latency is 1 cycle).
REQ-018 Opcodes 000-101 are ALU instructions: branch=0, alu_op=opcode.
REQ-019 Opcode 110 is BR, an unconditional branch: branch=1, branch_conditional=0, target=LUT[ir[5:3]].
REQ-020 Opcode 111 with ir[5:3] not equal to 111 is BZ, a conditional branch: branch=1, branch_conditional=1, target=LUT[ir[5:3]].
REQ-021 Opcode 111 with ir[5:3]=111 is HALT: branch=1, branch_conditional=0, target=PC, which freezes the program counter.
REQ-022 LUT is fixed: LUT[i] = 16*i (0, 16, 32, ..., 112).
REQ-023 A branch is taken when branch & ir_valid & (!branch_conditional | zero).
REQ-024 On a taken branch, the instruction fetched in that cycle is the delay slot: on that edge ir_valid SHALL load 0 (a one-cycle bubble), and a new fetch resumes from target on the next edge.
REQ-025 When ir_valid=0, branch, branch_conditional and alu_op SHALL be 0; target and operand are don't-care.
REQ-026 State machine: RUN to HALT on the edge where a valid HALT is held in ir; HALT to RUN only on reset.
REQ-027 In HALT: ir is frozen, ir_valid=0, done=1, branch=1, branch_conditional=0, target=PC.
REQ-028 A BZ with zero=0 is not taken: no flush, and the PC increments normally.
REQ-029 Back-to-back branches: the second branch sits in the flushed slot, so it is never executed.

Reset
REQ-030 On reset=1 at a clock edge: state=RUN, ir=0, ir_valid=0, done=0, br_count=0; this applies from any state, including HALT or a mid-flush cycle.
REQ-031 Outputs in the cycle after reset: branch=0, branch_conditional=0, alu_op=0, done=0.

Configuration
REQ-032 Macro FETCH_DECODE_PERF_CNT_EN defined: br_count SHALL increment by 1 on every taken branch (HALT excluded) and saturate at all-ones.
REQ-033 Macro undefined: br_count SHALL be constant 0, and no counter register is built.

Verification
REQ-034 Reset, then ROM holds ALU ops at 0-3 -> ir_valid=1 from cycle 1, alu_op tracks opcodes, branch=0 throughout.
REQ-035 BR with ir[5:3]=010 at address 5 -> branch=1, target=32, next ir_valid=0, following fetch comes from PC=32; br_count=1 when the macro is on.
REQ-036 BZ with index 001: zero=0 -> not taken, no bubble; zero=1 -> target=16 plus a bubble.
REQ-037 HALT word 9'b111111000 -> done=1 next cycle, PC held constant for 10+ cycles, br_count unchanged.
REQ-038 Reset asserted while in HALT -> done=0, state RUN, fetch restarts from PC=0.
REQ-039 BR immediately followed by BR -> only the first is taken; the second is flushed.
